// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer-type encodings and master index type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Index of one of the two masters.
  typedef logic mst_idx_t;

  // The competing master in a two-master system.
  function automatic mst_idx_t other_master(input mst_idx_t m);
    return ~m;
  endfunction

endpackage

// File: rtl/ahblite_arb2_hold.sv
// Per-master address/control hold register with its pending flag.
module ahblite_arb2_hold (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        capture_i,
  input  logic        clear_i,
  input  logic [31:0] haddr_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  output logic        pend_o,
  output logic [31:0] haddr_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o
);

  logic        pend_q,  pend_d;
  logic [31:0] addr_q,  addr_d;
  logic        write_q, write_d;
  logic [2:0]  size_q,  size_d;

  // Capture a deferred address phase, or retire it once it is granted.
  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    if (capture_i) begin
      pend_d  = 1'b1;
      addr_d  = haddr_i;
      write_d = hwrite_i;
      size_d  = hsize_i;
    end else if (clear_i) begin
      pend_d  = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  assign pend_o   = pend_q;
  assign haddr_o  = addr_q;
  assign hwrite_o = write_q;
  assign hsize_o  = size_q;

endmodule

// File: rtl/ahblite_arb2.sv
// Two-master AHB-Lite arbiter: zero-latency grant of live requests, losers
// parked in hold registers and replayed as NONSEQ when granted.
module ahblite_arb2
  import ahb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR_M0,
  input  logic [1:0]  HTRANS_M0,
  input  logic        HWRITE_M0,
  input  logic [2:0]  HSIZE_M0,
  input  logic [31:0] HWDATA_M0,
  input  logic [31:0] HADDR_M1,
  input  logic [1:0]  HTRANS_M1,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M1,
  input  logic [31:0] HWDATA_M1,
  output logic [31:0] HRDATA_M0,
  output logic [31:0] HRDATA_M1,
  output logic        HREADY_M0,
  output logic        HREADY_M1,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        HMASTER
);

  logic [31:0] m_addr  [2];
  logic [1:0]  m_trans [2];
  logic        m_write [2];
  logic [2:0]  m_size  [2];
  logic [31:0] h_addr  [2];
  logic        h_write [2];
  logic [2:0]  h_size  [2];
  logic [1:0]  pend, live, req, capture, clear;

  mst_idx_t    gnt;
  logic        gnt_valid;
  logic        sel_pend;

  mst_idx_t    last_q, last_d;
  mst_idx_t    hmaster_q, hmaster_d;
  logic        dp_valid_q, dp_valid_d;
  mst_idx_t    dp_owner_q, dp_owner_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        bus_write_q, bus_write_d;
  logic [2:0]  bus_size_q, bus_size_d;

  assign m_addr[0]  = HADDR_M0;
  assign m_addr[1]  = HADDR_M1;
  assign m_trans[0] = HTRANS_M0;
  assign m_trans[1] = HTRANS_M1;
  assign m_write[0] = HWRITE_M0;
  assign m_write[1] = HWRITE_M1;
  assign m_size[0]  = HSIZE_M0;
  assign m_size[1]  = HSIZE_M1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mst
      // BUSY and IDLE have HTRANS[1]=0 and therefore never request.
      assign live[gi]    = m_trans[gi][1] & ~pend[gi];
      assign req[gi]     = pend[gi] | live[gi];
      assign capture[gi] = live[gi] & ~(gnt_valid & (gnt == 1'(gi)));
      assign clear[gi]   = pend[gi] & gnt_valid & (gnt == 1'(gi));

      ahblite_arb2_hold u_hold (
        .clk_i     (HCLK),
        .srst_i    (HRESET),
        .capture_i (capture[gi]),
        .clear_i   (clear[gi]),
        .haddr_i   (m_addr[gi]),
        .hwrite_i  (m_write[gi]),
        .hsize_i   (m_size[gi]),
        .pend_o    (pend[gi]),
        .haddr_o   (h_addr[gi]),
        .hwrite_o  (h_write[gi]),
        .hsize_o   (h_size[gi])
      );
    end
  endgenerate

  // Pick the winner; no grant is issued while the bus is stalled.
  always_comb begin
    gnt = 1'b0;
    if (req[0] & req[1]) begin
      gnt = (RR_EN != 0) ? other_master(last_q) : 1'b0;
    end else if (req[1]) begin
      gnt = 1'b1;
    end
    gnt_valid = HREADY & (|req);
  end

  // Address-phase mux: live path is combinational, pending path replays the hold.
  always_comb begin
    sel_pend = pend[gnt];
    HTRANS   = HTRANS_IDLE;
    HADDR    = bus_addr_q;
    HWRITE   = bus_write_q;
    HSIZE    = bus_size_q;
    if (gnt_valid) begin
      if (sel_pend) begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = h_addr[gnt];
        HWRITE = h_write[gnt];
        HSIZE  = h_size[gnt];
      end else begin
        HTRANS = m_trans[gnt];
        HADDR  = m_addr[gnt];
        HWRITE = m_write[gnt];
        HSIZE  = m_size[gnt];
        // A burst continuation cannot be SEQ on a bus just handed to a new owner.
        if ((m_trans[gnt] == HTRANS_SEQ) && (gnt != hmaster_q)) begin
          HTRANS = HTRANS_NONSEQ;
        end
      end
    end
  end

  // Next state for ownership, data phase and held bus control.
  always_comb begin
    last_d      = last_q;
    hmaster_d   = hmaster_q;
    dp_valid_d  = dp_valid_q;
    dp_owner_d  = dp_owner_q;
    bus_addr_d  = bus_addr_q;
    bus_write_d = bus_write_q;
    bus_size_d  = bus_size_q;
    if (HREADY) begin
      dp_valid_d = gnt_valid;
      if (gnt_valid) begin
        last_d      = gnt;
        hmaster_d   = gnt;
        dp_owner_d  = gnt;
        bus_addr_d  = HADDR;
        bus_write_d = HWRITE;
        bus_size_d  = HSIZE;
      end
    end
  end

  // State register; pointer starts at M1 so M0 wins the first contention.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_q      <= 1'b1;
      hmaster_q   <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_owner_q  <= 1'b0;
      bus_addr_q  <= '0;
      bus_write_q <= 1'b0;
      bus_size_q  <= '0;
    end else begin
      last_q      <= last_d;
      hmaster_q   <= hmaster_d;
      dp_valid_q  <= dp_valid_d;
      dp_owner_q  <= dp_owner_d;
      bus_addr_q  <= bus_addr_d;
      bus_write_q <= bus_write_d;
      bus_size_q  <= bus_size_d;
    end
  end

  assign HMASTER   = gnt_valid ? gnt : hmaster_q;
  assign HWDATA    = dp_owner_q ? HWDATA_M1 : HWDATA_M0;
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;
  assign HREADY_M0 = (dp_valid_q && (dp_owner_q == 1'b0)) ? HREADY : ~pend[0];
  assign HREADY_M1 = (dp_valid_q && (dp_owner_q == 1'b1)) ? HREADY : ~pend[1];

endmodule

// File: tb/tb_ahblite_arb2.sv
// Self-checking bench for ahblite_arb2 (round-robin and fixed-priority builds).
module tb_ahblite_arb2;
  import ahb_pkg::*;

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        mst;
    logic        rdy0;
    logic        rdy1;
  } exp_t;

  logic        HCLK, HRESET, HREADY;
  logic [31:0] HADDR_M0, HWDATA_M0, HADDR_M1, HWDATA_M1, HRDATA;
  logic [1:0]  HTRANS_M0, HTRANS_M1;
  logic        HWRITE_M0, HWRITE_M1;
  logic [2:0]  HSIZE_M0, HSIZE_M1;

  logic [31:0] r_hrdata0, r_hrdata1, r_haddr, r_hwdata;
  logic        r_rdy0, r_rdy1, r_hwrite, r_hmaster;
  logic [1:0]  r_htrans;
  logic [2:0]  r_hsize;
  logic [31:0] f_hrdata0, f_hrdata1, f_haddr, f_hwdata;
  logic        f_rdy0, f_rdy1, f_hwrite, f_hmaster;
  logic [1:0]  f_htrans;
  logic [2:0]  f_hsize;

  exp_t r_obs, f_obs;
  assign r_obs = {r_htrans, r_haddr, r_hmaster, r_rdy0, r_rdy1};
  assign f_obs = {f_htrans, f_haddr, f_hmaster, f_rdy0, f_rdy1};

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ahblite_arb2 #(.RR_EN(1)) dut_rr (
    .HCLK(HCLK), .HRESET(HRESET),
    .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
    .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1),
    .HRDATA_M0(r_hrdata0), .HRDATA_M1(r_hrdata1),
    .HREADY_M0(r_rdy0), .HREADY_M1(r_rdy1),
    .HADDR(r_haddr), .HTRANS(r_htrans), .HWRITE(r_hwrite), .HSIZE(r_hsize),
    .HWDATA(r_hwdata), .HREADY(HREADY), .HRDATA(HRDATA), .HMASTER(r_hmaster)
  );

  ahblite_arb2 #(.RR_EN(0)) dut_fx (
    .HCLK(HCLK), .HRESET(HRESET),
    .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
    .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1),
    .HRDATA_M0(f_hrdata0), .HRDATA_M1(f_hrdata1),
    .HREADY_M0(f_rdy0), .HREADY_M1(f_rdy1),
    .HADDR(f_haddr), .HTRANS(f_htrans), .HWRITE(f_hwrite), .HSIZE(f_hsize),
    .HWDATA(f_hwdata), .HREADY(HREADY), .HRDATA(HRDATA), .HMASTER(f_hmaster)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_all();
    HTRANS_M0 = HTRANS_IDLE;
    HTRANS_M1 = HTRANS_IDLE;
    HREADY    = 1'b1;
  endtask

  task automatic apply_reset();
    HRESET = 1'b1;
    idle_all();
    step();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    apply_reset();
    exp_q.push_back(exp_t'({HTRANS_IDLE, 32'h0, 1'b0, 1'b1, 1'b1}));
    @(negedge HCLK);
    e = exp_q.pop_front();
    n_cmp++;
    if (r_htrans !== e.trans) begin n_err++; $display("FAIL reset_htrans got %h want %h", r_htrans, e.trans); end
    n_cmp++;
    if ({r_rdy0, r_rdy1} !== {e.rdy0, e.rdy1}) begin n_err++; $display("FAIL reset_hready got %b want %b", {r_rdy0, r_rdy1}, {e.rdy0, e.rdy1}); end
    n_cmp++;
    if (r_hmaster !== e.mst) begin n_err++; $display("FAIL reset_hmaster got %b want %b", r_hmaster, e.mst); end
    n_cmp++;
    if ({f_htrans, f_rdy0, f_rdy1, f_hmaster} !== {e.trans, e.rdy0, e.rdy1, e.mst}) begin
      n_err++; $display("FAIL reset_fixed got %h want %h", {f_htrans, f_rdy0, f_rdy1, f_hmaster}, {e.trans, e.rdy0, e.rdy1, e.mst});
    end
    $display("reset: htrans=%h hready_m0=%b hready_m1=%b hmaster=%b", r_htrans, r_rdy0, r_rdy1, r_hmaster);
    step();
  endtask

  task automatic test_m0_read();
    exp_t e;
    apply_reset();
    HRDATA = 32'hCAFE_0001;
    HADDR_M0 = 32'h2000_0000; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd2; HTRANS_M0 = HTRANS_NONSEQ;
    exp_q.push_back(exp_t'({HTRANS_NONSEQ, 32'h2000_0000, 1'b0, 1'b1, 1'b1}));
    exp_q.push_back(exp_t'({HTRANS_IDLE,   32'h2000_0000, 1'b0, 1'b1, 1'b1}));
    for (int c = 0; c < 2; c++) begin
      if (c == 1) HTRANS_M0 = HTRANS_IDLE;
      @(negedge HCLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (r_obs !== e) begin n_err++; $display("FAIL m0_read c%0d got %h want %h", c, r_obs, e); end
      $display("m0_read c%0d: htrans=%h haddr=%h hready_m0=%b", c, r_htrans, r_haddr, r_rdy0);
      step();
    end
    n_cmp++;
    if (r_hrdata0 !== 32'hCAFE_0001) begin n_err++; $display("FAIL m0_read_hrdata got %h want %h", r_hrdata0, 32'hCAFE_0001); end
  endtask

  task automatic test_both();
    exp_t e;
    int   low1;
    apply_reset();
    low1 = 0;
    HADDR_M0 = 32'h0000_1000; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd2; HWDATA_M0 = 32'h1111_1111;
    HADDR_M1 = 32'h0000_2004; HWRITE_M1 = 1'b1; HSIZE_M1 = 3'd2; HWDATA_M1 = 32'hA5A5_A5A5;
    HTRANS_M0 = HTRANS_NONSEQ; HTRANS_M1 = HTRANS_NONSEQ;
    exp_q.push_back(exp_t'({HTRANS_NONSEQ, 32'h0000_1000, 1'b0, 1'b1, 1'b1}));
    exp_q.push_back(exp_t'({HTRANS_NONSEQ, 32'h0000_2004, 1'b1, 1'b1, 1'b0}));
    exp_q.push_back(exp_t'({HTRANS_IDLE,   32'h0000_2004, 1'b1, 1'b1, 1'b1}));
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin HTRANS_M0 = HTRANS_IDLE; HTRANS_M1 = HTRANS_IDLE; end
      @(negedge HCLK);
      e = exp_q.pop_front();
      if (r_rdy1 === 1'b0) low1++;
      n_cmp++;
      if (r_obs !== e) begin n_err++; $display("FAIL both c%0d got %h want %h", c, r_obs, e); end
      if (c == 1) begin
        n_cmp++;
        if ({r_hwrite, r_hwdata} !== {1'b1, 32'h1111_1111}) begin
          n_err++; $display("FAIL both_m1_write got %h want %h", {r_hwrite, r_hwdata}, {1'b1, 32'h1111_1111});
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (r_hwdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL both_hwdata got %h want %h", r_hwdata, 32'hA5A5_A5A5); end
      end
      $display("both c%0d: htrans=%h haddr=%h hmaster=%b hready_m1=%b hwdata=%h", c, r_htrans, r_haddr, r_hmaster, r_rdy1, r_hwdata);
      step();
    end
    n_cmp++;
    if (low1 !== 1) begin n_err++; $display("FAIL both_m1_low_cycles got %0d want %0d", low1, 1); end
  endtask

  task automatic test_wait_states();
    exp_t e;
    logic hr [6];
    hr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    HRDATA = 32'hBEEF_0042;
    HADDR_M0 = 32'h0000_3000; HWRITE_M0 = 1'b0; HTRANS_M0 = HTRANS_NONSEQ;
    HADDR_M1 = 32'h0000_4000; HWRITE_M1 = 1'b0; HTRANS_M1 = HTRANS_NONSEQ;
    exp_q.push_back(exp_t'({HTRANS_NONSEQ, 32'h0000_3000, 1'b0, 1'b1, 1'b1}));
    for (int c = 1; c < 4; c++) exp_q.push_back(exp_t'({HTRANS_IDLE, 32'h0000_3000, 1'b0, 1'b0, 1'b0}));
    exp_q.push_back(exp_t'({HTRANS_NONSEQ, 32'h0000_4000, 1'b1, 1'b1, 1'b0}));
    exp_q.push_back(exp_t'({HTRANS_IDLE,   32'h0000_4000, 1'b1, 1'b1, 1'b1}));
    for (int c = 0; c < 6; c++) begin
      HREADY = hr[c];
      if (c == 1) begin HTRANS_M0 = HTRANS_IDLE; HTRANS_M1 = HTRANS_IDLE; end
      @(negedge HCLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (r_obs !== e) begin n_err++; $display("FAIL wait c%0d got %h want %h", c, r_obs, e); end
      $display("wait c%0d: hready=%b htrans=%h haddr=%h hmaster=%b hready_m1=%b", c, HREADY, r_htrans, r_haddr, r_hmaster, r_rdy1);
      step();
    end
    n_cmp++;
    if (r_hrdata1 !== 32'hBEEF_0042) begin n_err++; $display("FAIL wait_hrdata_m1 got %h want %h", r_hrdata1, 32'hBEEF_0042); end
  endtask

  task automatic test_contention();
    exp_t e, ef;
    exp_t fx_q[$];
    apply_reset();
    HADDR_M0 = 32'h0000_0100; HWRITE_M0 = 1'b0; HTRANS_M0 = HTRANS_NONSEQ;
    HADDR_M1 = 32'h0000_0200; HWRITE_M1 = 1'b1; HTRANS_M1 = HTRANS_NONSEQ;
    for (int i = 0; i < 6; i++) begin
      // Round robin: owners alternate and each master parks while the other runs.
      exp_q.push_back(exp_t'({HTRANS_NONSEQ, ((i % 2) == 1) ? 32'h0000_0200 : 32'h0000_0100,
                              1'((i % 2) == 1), 1'((i == 0) || ((i % 2) == 1)), 1'((i % 2) == 0)}));
      // Fixed priority: M0 always, M1 stuck pending after the first cycle.
      fx_q.push_back(exp_t'({HTRANS_NONSEQ, 32'h0000_0100, 1'b0, 1'b1, 1'(i == 0)}));
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      e  = exp_q.pop_front();
      ef = fx_q.pop_front();
      n_cmp++;
      if (r_obs !== e) begin n_err++; $display("FAIL rr_contend c%0d got %h want %h", i, r_obs, e); end
      n_cmp++;
      if (f_obs !== ef) begin n_err++; $display("FAIL fixed_contend c%0d got %h want %h", i, f_obs, ef); end
      $display("contend c%0d: rr_hmaster=%b rr_haddr=%h fixed_hmaster=%b fixed_hready_m1=%b", i, r_hmaster, r_haddr, f_hmaster, f_rdy1);
      step();
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    HADDR_M0 = 32'h0000_5000; HTRANS_M0 = HTRANS_NONSEQ;
    HADDR_M1 = 32'h0000_6000; HTRANS_M1 = HTRANS_NONSEQ;
    step();
    HTRANS_M0 = HTRANS_IDLE; HTRANS_M1 = HTRANS_IDLE;
    HREADY = 1'b0;
    HRESET = 1'b1;
    @(negedge HCLK);
    n_cmp++;
    if (r_rdy1 !== 1'b0) begin n_err++; $display("FAIL rstmid_pend1_before got %b want %b", r_rdy1, 1'b0); end
    step();
    HRESET = 1'b0;
    HREADY = 1'b1;
    exp_q.push_back(exp_t'({HTRANS_IDLE, 32'h0, 1'b0, 1'b1, 1'b1}));
    exp_q.push_back(exp_t'({HTRANS_IDLE, 32'h0, 1'b0, 1'b1, 1'b1}));
    for (int c = 0; c < 2; c++) begin
      @(negedge HCLK);
      e = exp_q.pop_front();
      n_cmp++;
      if ({r_htrans, r_rdy0, r_rdy1, r_hmaster} !== {e.trans, e.rdy0, e.rdy1, e.mst}) begin
        n_err++; $display("FAIL rstmid_rr c%0d got %h want %h", c, {r_htrans, r_rdy0, r_rdy1, r_hmaster}, {e.trans, e.rdy0, e.rdy1, e.mst});
      end
      n_cmp++;
      if ({f_htrans, f_rdy0, f_rdy1, f_hmaster} !== {e.trans, e.rdy0, e.rdy1, e.mst}) begin
        n_err++; $display("FAIL rstmid_fixed c%0d got %h want %h", c, {f_htrans, f_rdy0, f_rdy1, f_hmaster}, {e.trans, e.rdy0, e.rdy1, e.mst});
      end
      $display("rstmid c%0d: htrans=%h hready_m0=%b hready_m1=%b hmaster=%b", c, r_htrans, r_rdy0, r_rdy1, r_hmaster);
      step();
    end
  endtask

  task automatic test_busy_seq();
    exp_t e;
    apply_reset();
    HADDR_M0 = 32'h0000_0500; HTRANS_M0 = HTRANS_BUSY;
    @(negedge HCLK);
    n_cmp++;
    if ({r_htrans, r_hmaster, r_rdy0} !== {HTRANS_IDLE, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL busy got %h want %h", {r_htrans, r_hmaster, r_rdy0}, {HTRANS_IDLE, 1'b0, 1'b1});
    end
    $display("busy: htrans=%h", r_htrans);
    step();
    HTRANS_M0 = HTRANS_NONSEQ;
    exp_q.push_back(exp_t'({HTRANS_NONSEQ, 32'h0000_0500, 1'b0, 1'b1, 1'b1}));
    exp_q.push_back(exp_t'({HTRANS_SEQ,    32'h0000_0504, 1'b0, 1'b1, 1'b1}));
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin HADDR_M0 = 32'h0000_0504; HTRANS_M0 = HTRANS_SEQ; end
      @(negedge HCLK);
      e = exp_q.pop_front();
      n_cmp++;
      if (r_obs !== e) begin n_err++; $display("FAIL seq c%0d got %h want %h", c, r_obs, e); end
      $display("seq c%0d: htrans=%h haddr=%h", c, r_htrans, r_haddr);
      step();
    end
    idle_all();
  endtask

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HRDATA = '0;
    HADDR_M0 = '0; HTRANS_M0 = HTRANS_IDLE; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd2; HWDATA_M0 = '0;
    HADDR_M1 = '0; HTRANS_M1 = HTRANS_IDLE; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'd2; HWDATA_M1 = '0;
    step();
    test_reset();
    test_m0_read();
    test_both();
    test_wait_states();
    test_contention();
    test_reset_mid();
    test_busy_seq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
